// File: rtl/readout_serializer.sv
// Readout word FIFO plus MSB-first serializer with frame markers.
// Accepts parallel words via valid/ready and shifts them out on a 1-bit link.
module readout_serializer #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 4,
   parameter int FRAME_LEN = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   input  logic [WIDTH-1:0]             in_data,
   output logic                         in_ready,
   input  logic                         ser_en,
   output logic                         ser_data,
   output logic                         ser_valid,
   output logic                         sof,
   output logic                         frame_done,
   output logic [$clog2(DEPTH+1)-1:0]   fifo_level
);

   localparam int LW  = $clog2(DEPTH + 1);
   localparam int PW  = $clog2(DEPTH);
   localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int WCW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

   localparam logic [LW-1:0]  DEPTH_L  = LW'(DEPTH);
   localparam logic [BCW-1:0] BIT_MAX  = BCW'(WIDTH - 1);
   localparam logic [WCW-1:0] WORD_MAX = WCW'(FRAME_LEN - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
   logic [WCW-1:0]   word_cnt_q, word_cnt_d;
   logic             ser_valid_q, ser_valid_d;
   logic             frame_done_q, frame_done_d;
   logic             push, pop;
   logic [WIDTH-1:0] head;

   // Ready looks only at the registered level, so a full FIFO stays
   // closed for one cycle even when the serializer pops.
   assign in_ready   = !rst && (level_q < DEPTH_L);
   assign push       = in_valid && in_ready;
   assign head       = mem_q[rd_ptr_q];

   assign ser_data   = shreg_q[WIDTH-1];
   assign ser_valid  = ser_valid_q;
   assign frame_done = frame_done_q;
   assign fifo_level = level_q;
   assign sof        = ser_valid_q && (word_cnt_q == '0)
                       && (bit_cnt_q == BIT_MAX);

   always_comb begin
      state_d      = state_q;
      shreg_d      = shreg_q;
      bit_cnt_d    = bit_cnt_q;
      word_cnt_d   = word_cnt_q;
      ser_valid_d  = ser_valid_q;
      frame_done_d = 1'b0;
      pop          = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (level_q != '0) begin
               pop         = 1'b1;
               shreg_d     = head;
               bit_cnt_d   = BIT_MAX;
               state_d     = SHIFT;
               ser_valid_d = 1'b1;
            end
         end
         SHIFT: begin
            if (ser_en) begin
               shreg_d   = shreg_q << 1;
               bit_cnt_d = bit_cnt_q - 1'b1;
               if (bit_cnt_q == '0) begin
                  word_cnt_d   = (word_cnt_q == WORD_MAX) ?
                                 '0 : word_cnt_q + 1'b1;
                  frame_done_d = (word_cnt_q == WORD_MAX);
                  if (level_q != '0) begin
                     pop       = 1'b1;
                     shreg_d   = head;
                     bit_cnt_d = BIT_MAX;
                  end else begin
                     bit_cnt_d   = '0;
                     state_d     = IDLE;
                     ser_valid_d = 1'b0;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      level_d  = level_q;
      if (push && !pop) begin
         level_d = level_q + 1'b1;
      end else if (!push && pop) begin
         level_d = level_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= in_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         level_q      <= '0;
         shreg_q      <= '0;
         bit_cnt_q    <= '0;
         word_cnt_q   <= '0;
         ser_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         level_q      <= level_d;
         shreg_q      <= shreg_d;
         bit_cnt_q    <= bit_cnt_d;
         word_cnt_q   <= word_cnt_d;
         ser_valid_q  <= ser_valid_d;
         frame_done_q <= frame_done_d;
      end
   end

endmodule

// File: tb/tb_readout_serializer.sv
// Scoreboard bench for readout_serializer: accepted words become an
// expected MSB-first bit stream with frame markers, checked by a monitor.
module tb_readout_serializer;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int FL    = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             ser_en;
   logic             ser_data;
   logic             ser_valid;
   logic             sof;
   logic             frame_done;
   logic [2:0]       fifo_level;

   readout_serializer #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .FRAME_LEN(FL)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .ser_en(ser_en), .ser_data(ser_data), .ser_valid(ser_valid),
      .sof(sof), .frame_done(frame_done), .fifo_level(fifo_level)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic b;
      logic s;
      logic l;
   } ebit_t;

   ebit_t exp_q[$];
   int    checks = 0;
   int    errors = 0;
   int    words_pushed = 0;
   int    fd_seen = 0;
   int    sof_seen = 0;
   logic  fd_pend = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   // Scoreboard push: every accepted word expands to its bit stream.
   always @(negedge clk) begin
      if (rst) begin
         words_pushed = 0;
      end else if (in_valid && in_ready) begin
         for (int i = WIDTH - 1; i >= 0; i--) begin
            ebit_t e;
            e.b = in_data[i];
            e.s = (i == WIDTH - 1) && (words_pushed % FL == 0);
            e.l = (i == 0) && (words_pushed % FL == FL - 1);
            exp_q.push_back(e);
         end
         words_pushed++;
      end
   end

   // Monitor: compares each presented bit, consumes it when ser_en is high.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         fd_pend = 1'b0;
      end else begin
         chk("frame_done", 32'(frame_done), 32'(fd_pend));
         if (frame_done) fd_seen++;
         fd_pend = 1'b0;
         if (ser_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_bit", 32'(ser_valid), 32'd0);
            end else begin
               chk("ser_data", 32'(ser_data), 32'(exp_q[0].b));
               chk("sof", 32'(sof), 32'(exp_q[0].s));
               if (sof) sof_seen++;
               if (ser_en) begin
                  fd_pend = exp_q[0].l;
                  exp_q.delete(0);
               end
            end
         end else begin
            chk("sof_idle", 32'(sof), 32'd0);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [WIDTH-1:0] d);
      logic done;
      done = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      for (int n = 0; n < 200 && !done; n++) begin
         @(negedge clk);
         if (in_ready) done = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      chk("push_timeout", 32'(done), 32'd1);
   endtask

   task automatic drain(input logic rnd);
      logic done;
      done = 1'b0;
      for (int n = 0; n < 2000 && !done; n++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !ser_valid) begin
            done = 1'b1;
         end else begin
            tick();
            ser_en = rnd ? 1'($urandom % 2) : 1'b1;
         end
      end
      chk("drain_timeout", 32'(done), 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int   s0, f0, gap, quiet;
      logic acc;
      rst = 1'b1; in_valid = 1'b0; in_data = '0; ser_en = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_ser_valid", 32'(ser_valid), 32'd0);
      chk("rst_level", 32'(fifo_level), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_ser_data", 32'(ser_data), 32'd0);
      chk("rst_frame_done", 32'(frame_done), 32'd0);
      tick(); rst = 1'b0;
      @(negedge clk);
      chk("rel_in_ready", 32'(in_ready), 32'd1);
      chk("rel_ser_valid", 32'(ser_valid), 32'd0);

      // single word and latency
      tick(); ser_en = 1'b1;
      s0 = sof_seen;
      push_word(8'hA1);
      @(negedge clk);
      chk("lat_early", 32'(ser_valid), 32'd0);
      @(negedge clk);
      chk("lat_msb", 32'(ser_valid), 32'd1);
      drain(1'b0);
      chk("single_sof_cnt", 32'(sof_seen - s0), 32'd1);

      // back-to-back words, no bubble
      tick();
      push_word(8'hB2);
      push_word(8'hC3);
      gap = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (!ser_valid) gap++;
      end
      chk("b2b_gap", 32'(gap), 32'd0);
      drain(1'b0);

      // backpressure
      tick(); ser_en = 1'b0;
      for (int i = 0; i < 5; i++) push_word(8'h10 + 8'(i));
      @(negedge clk);
      chk("bp_level", 32'(fifo_level), 32'd4);
      in_valid = 1'b1; in_data = 8'h15;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_stall", 32'(in_ready), 32'd0);
      end
      acc = 1'b0;
      for (int n = 0; n < 200 && !acc; n++) begin
         tick(); ser_en = 1'($urandom % 2);
         @(negedge clk);
         if (in_ready) acc = 1'b1;
      end
      tick(); in_valid = 1'b0;
      chk("bp_accept", 32'(acc), 32'd1);
      drain(1'b1);

      // push/pop collision at level 2
      tick(); ser_en = 1'b0;
      for (int i = 0; i < 3; i++) push_word(8'($urandom));
      ser_en = 1'b1;
      repeat (7) @(posedge clk);
      #1;
      chk("coll_pre", 32'(fifo_level), 32'd2);
      in_valid = 1'b1; in_data = 8'($urandom);
      tick(); in_valid = 1'b0; ser_en = 1'b0;
      @(negedge clk);
      chk("coll_level", 32'(fifo_level), 32'd2);
      drain(1'b1);

      // frame markers from a fresh reset
      tick(); rst = 1'b1;
      tick(); rst = 1'b0; ser_en = 1'b1;
      s0 = sof_seen; f0 = fd_seen;
      push_word(8'hE5);
      push_word(8'hF6);
      push_word(8'h11);
      drain(1'b0);
      chk("frame_sof_cnt", 32'(sof_seen - s0), 32'd2);
      chk("frame_done_cnt", 32'(fd_seen - f0), 32'd1);

      // random traffic
      for (int n = 0; n < 300; n++) begin
         tick();
         in_valid = 1'($urandom % 2);
         in_data  = 8'($urandom);
         ser_en   = ($urandom % 4) != 0;
      end
      tick(); in_valid = 1'b0;
      drain(1'b1);

      // reset mid-word with 3 words queued
      tick(); ser_en = 1'b0;
      for (int i = 0; i < 4; i++) push_word(8'($urandom));
      @(negedge clk);
      chk("mid_level", 32'(fifo_level), 32'd3);
      chk("mid_valid", 32'(ser_valid), 32'd1);
      tick(); rst = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(ser_valid), 32'd0);
      chk("mid_rst_level", 32'(fifo_level), 32'd0);
      chk("mid_rst_ready", 32'(in_ready), 32'd0);
      tick(); tick(); rst = 1'b0; ser_en = 1'b1;
      @(negedge clk);
      chk("mid_rel_ready", 32'(in_ready), 32'd1);
      quiet = 0;
      repeat (6) begin
         @(negedge clk);
         if (ser_valid) quiet++;
      end
      chk("mid_rel_quiet", 32'(quiet), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/readout_serializer.md
Name: readout_serializer

Overview:
Downstream stage of the pixel/memory readout buffer. It accepts the buffer's parallel 8-bit readout words through a valid/ready handshake and holds them in a small FIFO. It shifts each word out MSB-first on a 1-bit link under a link-side shift enable. It also marks frame boundaries (start-of-frame, frame-done) so the off-chip receiver can re-align words.

Parameters:
WIDTH, 8, readout word width in bits
DEPTH, 4, FIFO entries; power of 2, >= 2
FRAME_LEN, 16, words per frame; >= 1

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous reset, active-high
in_valid  input  1  upstream word valid (driven alongside readout buffer out_value)
in_data  input  WIDTH  readout word
in_ready  output  1  FIFO can accept a word this cycle
ser_en  input  1  link consumes one bit on this clock edge when high
ser_data  output  1  current serial bit, MSB first
ser_valid  output  1  ser_data holds a valid bit
sof  output  1  high while the first bit of word 0 of a frame is presented
frame_done  output  1  one-cycle pulse after the last bit of word FRAME_LEN-1 is consumed
fifo_level  output  $clog2(DEPTH+1)  words currently stored in the FIFO

Behaviour:
- Reset (async assert, sync release):
  - FIFO empty, fifo_level=0, FSM=IDLE, shift reg=0, bit_cnt=0, word_cnt=0.
  - ser_data=0, ser_valid=0, sof=0, frame_done=0.
  - in_ready forced 0 while rst=1.
  - Reset mid-word aborts the word; the partial word and all FIFO contents are discarded.
- FIFO handshake:
  - in_ready = !rst && (fifo_level < DEPTH); it is derived from registered fifo_level only and never depends on the same-cycle pop.
  - Push on any edge with in_valid && in_ready. in_data is ignored when in_valid=0.
  - Push and pop on the same edge leave fifo_level unchanged.
  - When full, in_ready=0 even if a pop occurs that cycle; it reopens on the next cycle.
  - Read/write pointers are $clog2(DEPTH) bits and wrap naturally.
- Serializer FSM:
  - IDLE: ser_valid=0. If fifo_level!=0, pop the head word into the shift reg, set bit_cnt=WIDTH-1, go to SHIFT.
  - SHIFT: ser_valid=1, ser_data=shreg[WIDTH-1].
    - On an edge with ser_en=1: shift left by 1 and decrement bit_cnt.
    - If bit_cnt==0 on that edge (last bit consumed): pop the next word and stay in SHIFT with bit_cnt=WIDTH-1 if the FIFO is non-empty (zero-bubble back-to-back); otherwise go to IDLE.
    - ser_en=0: hold shreg, bit_cnt and ser_data stable.
- Latency: a word pushed on edge N is popped on edge N+1. Its MSB is presented (ser_valid=1) in the cycle after edge N+1. With ser_en held high, it takes WIDTH cycles to drain.
- Frame tracking:
  - word_cnt increments when the last bit of a word is consumed, wrapping FRAME_LEN-1 -> 0.
  - sof = ser_valid && word_cnt==0 && bit_cnt==WIDTH-1.
  - frame_done is a registered one-cycle pulse, asserted in the cycle after the edge that consumes the last bit of word FRAME_LEN-1.
- ser_en while IDLE has no effect.
- Output registers are updated only by the FSM. All outputs except in_ready and sof come straight from registers; in_ready and sof are simple decodes of registered state.

Test Plan:
- Reset:
  - Drive rst=1 mid-operation with 3 words queued and ser_valid=1 -> in the same cycle ser_valid=0, fifo_level=0, in_ready=0.
  - Release rst -> next cycle in_ready=1 and no serial output appears.
- Single word:
  - Push 8'hA1 with ser_en=1 -> ser_valid rises 1 cycle after the push edge.
  - ser_data sequence over 8 cycles is 1,0,1,0,0,0,0,1.
  - sof=1 on the first bit only, then ser_valid=0.
- Back-to-back:
  - Push 8'hB2 then 8'hC3 on consecutive cycles, ser_en=1 -> 16 contiguous valid bits 10110010 11000011 with no gap cycle.
- Backpressure:
  - Push 6 words 8'h10..8'h15 with ser_en=0 -> fifo_level reaches 4 (one word already moved to the shift reg), then in_ready=0 and 8'h15 stalls.
  - Toggle ser_en -> all 6 words emerge in order; ser_data holds steady while ser_en=0.
- Frame: FRAME_LEN=2, push 8'hE5, 8'hF6, 8'h11:
  - frame_done pulses exactly once, the cycle after the 16th consumed bit.
  - sof is asserted for the first bit of 8'hE5 and of 8'h11.
- Push/pop collision: at fifo_level=2, push on the same edge the shift reg pops -> fifo_level stays 2 and data order is preserved.
